mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage directly downstream of the execute stage. Registers ALU results toward write-back.
//  Runs byte/half/word loads and stores over a req/ack data bus with byte enables.
//  Stalls the upstream pipeline while a bus access is outstanding.
//  Flags misaligned accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT   16   max BUSY cycles without dbus_ack_i before abort (>=1)
//  CNT_W     5    timeout counter width; must hold TIMEOUT
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_i          in   1   asynchronous, active-high reset
//  reg_waddr_i    in   5   dest register from execute
//  reg_we_i       in   1   register write enable from execute
//  reg_wdata_i    in   32  ALU result from execute
//  mem_addr_i     in   32  effective byte address
//  mem_data_i     in   32  store data (rs2)
//  mem_we_i       in   1   1 = store
//  mem_op_i       in   4   0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; others = NOP
//  stall_o        out  1   hold execute/decode inputs stable (combinational)
//  dbus_req_o     out  1   bus request, registered
//  dbus_we_o      out  1   bus write
//  dbus_addr_o    out  32  word address, {addr[31:2],2'b00}
//  dbus_be_o      out  4   byte enables
//  dbus_wdata_o   out  32  lane-replicated store data
//  dbus_rdata_i   in   32  read data, valid only when dbus_ack_i=1
//  dbus_ack_i     in   1   one-cycle completion strobe
//  wb_waddr_o     out  5   write-back register address, registered
//  wb_we_o        out  1   write-back enable, registered
//  wb_wdata_o     out  32  write-back data, registered
//  misalign_o     out  1   1-cycle pulse: misaligned access dropped
//  bus_err_o      out  1   1-cycle pulse: access aborted on timeout
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0, counter 0.
//  Op classes: mem op = mem_op_i in 1..8. Lane = mem_addr_i[1:0].
//    Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
//  FSM states: IDLE, BUSY.
//   IDLE, non-mem op: wb_* <= reg_*_i at the next edge (1-cycle latency). stall_o=0.
//   IDLE, misaligned mem op: no bus access. wb_we_o<=0, misalign_o<=1, stall_o=0.
//   IDLE, aligned mem op: stall_o=1 combinationally.
//     Next edge: latch op, lane and dest. dbus_req_o<=1, drive bus fields, wb_we_o<=0 (bubble), counter<=0, ->BUSY.
//   BUSY: bus fields held constant. Inputs ignored.
//     stall_o = !dbus_ack_i && (counter != TIMEOUT-1).
//   BUSY with ack: dbus_req_o<=0, ->IDLE.
//     Load: wb_we_o<=latched reg_we, wb_wdata_o<=formatted rdata.
//     Store: wb_we_o<=0.
//   BUSY, no ack, counter==TIMEOUT-1: dbus_req_o<=0, bus_err_o<=1, wb_we_o<=0, ->IDLE.
//   BUSY otherwise: counter++.
//   Ack in the same cycle as timeout: ack wins, no bus_err_o.
//  Load latency with ack on first BUSY cycle: result on wb_* 2 edges after the op is presented.
//  Load format (byte at lane L = rdata[8L+:8], half = rdata[16*addr[1]+:16]):
//    LB/LH sign-extend to 32 bits. LBU/LHU zero-extend. LW passes rdata through.
//  Store format:
//    SB: be=4'b0001<<L, wdata={4{data[7:0]}}.
//    SH: be=4'b0011<<(2*addr[1]), wdata={2{data[15:0]}}.
//    SW: be=4'b1111, wdata=data.
//    Loads: be=4'b1111, dbus_we_o=0.
//  wb_we_o is forced 0 whenever the destination is x0.
//  Address arithmetic is 32-bit wrap. 0xFFFFFFFF is byte lane 3 of word 0xFFFFFFFC.
//  dbus_ack_i while IDLE: ignored.
//  Reset asserted mid-BUSY: immediate return to IDLE; req, stall and wb outputs cleared. The access is lost.
// TESTING
//  ADD result 0x1234 to x5, non-mem -> next edge wb_we_o=1, wb_waddr_o=5, wb_wdata_o=0x1234, stall_o=0.
//  LB addr 0x103, ack first BUSY cycle, rdata 0x80AABBCC
//    -> dbus_addr_o=0x100, wb_wdata_o=0xFFFFFF80. Same with LBU -> 0x00000080.
//  SB addr 0x102, data 0x5A, ack after 3 wait cycles
//    -> be=0100, wdata=0x5A5A5A5A, stall_o high 4 cycles, wb_we_o=0.
//  LW addr 0x101 -> no dbus_req_o, misalign_o pulse, wb_we_o=0, stall_o=0.
//  LW, TIMEOUT=16, no ack -> 16 BUSY cycles, then bus_err_o pulse, req drops, IDLE.
//  LH, reset asserted in 2nd BUSY cycle -> all outputs 0 immediately.
//    Next op after reset is processed normally.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: forwards ALU results to write-back and performs
// byte/half/word loads and stores over a req/ack bus, stalling upstream while busy.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        reg_we_i,
  input  logic [31:0] reg_wdata_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_op_i,
  output logic        stall_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic [4:0]  wb_waddr_o,
  output logic        wb_we_o,
  output logic [31:0] wb_wdata_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       op_r;
  logic [1:0]       lane_r;
  logic [4:0]       dest_r;
  logic             dest_we_r;
  logic             is_mem_s;
  logic             is_store_s;
  logic             misalign_s;
  logic             timeout_s;
  logic             stall_s;
  logic             unused_s;

  // Opcode decode alone selects the bus direction; mem_we_i is redundant with it.
  assign unused_s = mem_we_i;

  function automatic logic [31:0] load_fmt(input logic [3:0] op, input logic [1:0] lane,
                                           input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = 8'd0;
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   load_fmt = {{24{b[7]}}, b};
      OP_LH:   load_fmt = {{16{h[15]}}, h};
      OP_LBU:  load_fmt = {24'd0, b};
      OP_LHU:  load_fmt = {16'd0, h};
      OP_LW:   load_fmt = rdata;
      default: load_fmt = rdata;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] lane);
    case (op)
      OP_SB:   store_be = 4'b0001 << lane;
      OP_SH:   store_be = lane[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [3:0] op, input logic [31:0] d);
    case (op)
      OP_SB:   store_wdata = {4{d[7:0]}};
      OP_SH:   store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    is_load = (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  // Classify the incoming operation.
  always_comb begin
    is_mem_s   = (mem_op_i >= OP_LB) && (mem_op_i <= OP_SW);
    is_store_s = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
    case (mem_op_i)
      OP_LH, OP_LHU, OP_SH: misalign_s = mem_addr_i[0];
      OP_LW, OP_SW:         misalign_s = (mem_addr_i[1:0] != 2'd0);
      default:              misalign_s = 1'b0;
    endcase
  end

  assign timeout_s = (cnt_r == CNT_W'(TIMEOUT - 1));

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and stall decode.
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (is_mem_s && !misalign_s) begin
          state_nxt_s = BUSY;
          stall_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (dbus_ack_i || timeout_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY;
        end
        stall_s = !dbus_ack_i && !timeout_s;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Reset must release the upstream pipeline even if a memory op is being presented.
  assign stall_o = stall_s & ~rst_i;

  // Bus, write-back and status registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r        <= '0;
      op_r         <= 4'd0;
      lane_r       <= 2'd0;
      dest_r       <= 5'd0;
      dest_we_r    <= 1'b0;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= 32'd0;
      dbus_be_o    <= 4'd0;
      dbus_wdata_o <= 32'd0;
      wb_waddr_o   <= 5'd0;
      wb_we_o      <= 1'b0;
      wb_wdata_o   <= 32'd0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!is_mem_s) begin
            wb_waddr_o <= reg_waddr_i;
            wb_wdata_o <= reg_wdata_i;
            wb_we_o    <= reg_we_i && (reg_waddr_i != 5'd0);
          end else if (misalign_s) begin
            wb_we_o    <= 1'b0;
            misalign_o <= 1'b1;
          end else begin
            op_r         <= mem_op_i;
            lane_r       <= mem_addr_i[1:0];
            dest_r       <= reg_waddr_i;
            dest_we_r    <= reg_we_i;
            dbus_req_o   <= 1'b1;
            dbus_we_o    <= is_store_s;
            dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            dbus_be_o    <= store_be(mem_op_i, mem_addr_i[1:0]);
            dbus_wdata_o <= store_wdata(mem_op_i, mem_data_i);
            wb_we_o      <= 1'b0;
            cnt_r        <= '0;
          end
        end
        BUSY: begin
          if (dbus_ack_i) begin
            dbus_req_o <= 1'b0;
            if (is_load(op_r)) begin
              wb_waddr_o <= dest_r;
              wb_wdata_o <= load_fmt(op_r, lane_r, dbus_rdata_i);
              wb_we_o    <= dest_we_r && (dest_r != 5'd0);
            end else begin
              wb_we_o <= 1'b0;
            end
          end else if (timeout_s) begin
            dbus_req_o <= 1'b0;
            bus_err_o  <= 1'b1;
            wb_we_o    <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          dbus_req_o <= 1'b0;
          wb_we_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: forwarding, loads/stores, misalignment,
// timeout, ack-vs-timeout priority and reset during an outstanding access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  reg_waddr;
  logic        reg_we;
  logic [31:0] reg_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic [3:0]  mem_op;
  logic        stall;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;
  logic [4:0]  wb_waddr;
  logic        wb_we;
  logic [31:0] wb_wdata;
  logic        misalign;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk_i(clk), .rst_i(rst),
    .reg_waddr_i(reg_waddr), .reg_we_i(reg_we), .reg_wdata_i(reg_wdata),
    .mem_addr_i(mem_addr), .mem_data_i(mem_data), .mem_we_i(mem_we), .mem_op_i(mem_op),
    .stall_o(stall),
    .dbus_req_o(dbus_req), .dbus_we_o(dbus_we), .dbus_addr_o(dbus_addr),
    .dbus_be_o(dbus_be), .dbus_wdata_o(dbus_wdata),
    .dbus_rdata_i(dbus_rdata), .dbus_ack_i(dbus_ack),
    .wb_waddr_o(wb_waddr), .wb_we_o(wb_we), .wb_wdata_o(wb_wdata),
    .misalign_o(misalign), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_nop();
    mem_op = 4'd0; mem_we = 1'b0; reg_we = 1'b0;
  endtask

  task automatic alu_op(input logic [3:0] op, input logic [4:0] waddr, input logic [31:0] wdata);
    @(negedge clk);
    mem_op = op; mem_we = 1'b0; reg_waddr = waddr; reg_we = 1'b1; reg_wdata = wdata;
    mem_addr = 32'h0000_0100;
  endtask

  task automatic run_access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] rdata,
                            input logic [4:0] waddr, input int waits,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic exp_wb_we,
                            input logic [31:0] exp_wb_data);
    int stall_hi;
    logic is_st;
    is_st = (op >= 4'd6);
    @(negedge clk);
    mem_op = op; mem_addr = addr; mem_data = data; mem_we = is_st;
    reg_waddr = waddr; reg_we = 1'b1; reg_wdata = 32'hDEAD_BEEF;
    #1;
    stall_hi = stall ? 1 : 0;
    @(posedge clk); #1;
    check({tag, "_req"}, {31'd0, dbus_req}, 32'd1);
    check({tag, "_addr"}, dbus_addr, exp_addr);
    check({tag, "_be"}, {28'd0, dbus_be}, {28'd0, exp_be});
    check({tag, "_we"}, {31'd0, dbus_we}, {31'd0, is_st});
    if (is_st) check({tag, "_wdata"}, dbus_wdata, exp_wdata);
    check({tag, "_bubble"}, {31'd0, wb_we}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      if (stall) stall_hi++;
      @(posedge clk); #1;
    end
    dbus_ack = 1'b1; dbus_rdata = rdata;
    #1;
    if (stall) stall_hi++;
    check({tag, "_stallcyc"}, 32'(stall_hi), 32'(waits + 1));
    @(posedge clk); #1;
    dbus_ack = 1'b0; dbus_rdata = 32'd0;
    set_nop();
    check({tag, "_req_drop"}, {31'd0, dbus_req}, 32'd0);
    check({tag, "_wb_we"}, {31'd0, wb_we}, {31'd0, exp_wb_we});
    if (exp_wb_we) begin
      check({tag, "_wb_data"}, wb_wdata, exp_wb_data);
      check({tag, "_wb_addr"}, {27'd0, wb_waddr}, {27'd0, waddr});
    end
  endtask

  task automatic run_timeout(input string tag, input logic ack_last);
    int stall_hi;
    int req_hi;
    stall_hi = 0; req_hi = 0;
    @(negedge clk);
    mem_op = 4'd3; mem_addr = 32'h0000_0200; mem_we = 1'b0;
    reg_waddr = 5'd3; reg_we = 1'b1; reg_wdata = 32'd0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15 && ack_last) begin
        dbus_ack = 1'b1; dbus_rdata = 32'hCAFE_F00D;
        #1;
      end
      if (stall) stall_hi++;
      if (dbus_req) req_hi++;
      @(posedge clk); #1;
    end
    dbus_ack = 1'b0; dbus_rdata = 32'd0;
    set_nop();
    check({tag, "_stallcyc"}, 32'(stall_hi), 32'd15);
    check({tag, "_reqcyc"}, 32'(req_hi), 32'd16);
    check({tag, "_req_drop"}, {31'd0, dbus_req}, 32'd0);
    check({tag, "_bus_err"}, {31'd0, bus_err}, {31'd0, ~ack_last});
    check({tag, "_wb_we"}, {31'd0, wb_we}, {31'd0, ack_last});
    if (ack_last) check({tag, "_wb_data"}, wb_wdata, 32'hCAFE_F00D);
    @(posedge clk); #1;
    check({tag, "_err_pulse"}, {31'd0, bus_err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    reg_waddr = 5'd0; reg_we = 1'b0; reg_wdata = 32'd0;
    mem_addr = 32'd0; mem_data = 32'd0; mem_we = 1'b0; mem_op = 4'd0;
    dbus_rdata = 32'd0; dbus_ack = 1'b0;
    #2;
    check("rst_req", {31'd0, dbus_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_wb_we", {31'd0, wb_we}, 32'd0);
    check("rst_be", {28'd0, dbus_be}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Plain ALU forwarding.
    alu_op(4'd0, 5'd5, 32'h0000_1234);
    #1 check("add_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check("add_wb_we", {31'd0, wb_we}, 32'd1);
    check("add_wb_addr", {27'd0, wb_waddr}, 32'd5);
    check("add_wb_data", wb_wdata, 32'h0000_1234);
    check("add_req", {31'd0, dbus_req}, 32'd0);

    // Destination x0 never writes.
    alu_op(4'd0, 5'd0, 32'h0000_5555);
    @(posedge clk); #1;
    check("x0_wb_we", {31'd0, wb_we}, 32'd0);

    // Undefined opcode behaves as NOP.
    alu_op(4'd12, 5'd4, 32'h0BAD_0004);
    #1 check("op12_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check("op12_wb_we", {31'd0, wb_we}, 32'd1);
    check("op12_wb_data", wb_wdata, 32'h0BAD_0004);
    check("op12_req", {31'd0, dbus_req}, 32'd0);

    // Loads: sign/zero extension and lane selection.
    run_access("lb",  4'd1, 32'h0000_0103, 32'd0, 32'h80AA_BBCC, 5'd7, 0,
               32'h0000_0100, 4'b1111, 32'd0, 1'b1, 32'hFFFF_FF80);
    run_access("lbu", 4'd4, 32'h0000_0103, 32'd0, 32'h80AA_BBCC, 5'd7, 0,
               32'h0000_0100, 4'b1111, 32'd0, 1'b1, 32'h0000_0080);
    run_access("lh",  4'd2, 32'h0000_0102, 32'd0, 32'h80AA_BBCC, 5'd8, 1,
               32'h0000_0100, 4'b1111, 32'd0, 1'b1, 32'hFFFF_80AA);
    run_access("lhu", 4'd5, 32'h0000_0100, 32'd0, 32'h80AA_BBCC, 5'd8, 0,
               32'h0000_0100, 4'b1111, 32'd0, 1'b1, 32'h0000_BBCC);
    run_access("lw",  4'd3, 32'h0000_0104, 32'd0, 32'h80AA_BBCC, 5'd9, 2,
               32'h0000_0104, 4'b1111, 32'd0, 1'b1, 32'h80AA_BBCC);
    run_access("lb_top", 4'd1, 32'hFFFF_FFFF, 32'd0, 32'h7F00_0000, 5'd11, 0,
               32'hFFFF_FFFC, 4'b1111, 32'd0, 1'b1, 32'h0000_007F);
    run_access("lb_x0", 4'd1, 32'h0000_0100, 32'd0, 32'h0000_00FF, 5'd0, 0,
               32'h0000_0100, 4'b1111, 32'd0, 1'b0, 32'd0);

    // Stores.
    run_access("sb", 4'd6, 32'h0000_0102, 32'h0000_005A, 32'd0, 5'd6, 3,
               32'h0000_0100, 4'b0100, 32'h5A5A_5A5A, 1'b0, 32'd0);
    run_access("sh", 4'd7, 32'h0000_0102, 32'h1234_ABCD, 32'd0, 5'd6, 0,
               32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'd0);
    run_access("sw", 4'd8, 32'h0000_0108, 32'h1122_3344, 32'd0, 5'd6, 1,
               32'h0000_0108, 4'b1111, 32'h1122_3344, 1'b0, 32'd0);

    // Misaligned word load after a write so the dropped write-back is visible.
    alu_op(4'd0, 5'd2, 32'h0000_2222);
    @(negedge clk);
    mem_op = 4'd3; mem_addr = 32'h0000_0101; reg_waddr = 5'd2; reg_we = 1'b1;
    #1 check("mis_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    set_nop();
    check("mis_req", {31'd0, dbus_req}, 32'd0);
    check("mis_pulse", {31'd0, misalign}, 32'd1);
    check("mis_wb_we", {31'd0, wb_we}, 32'd0);
    @(posedge clk); #1;
    check("mis_pulse_end", {31'd0, misalign}, 32'd0);

    run_timeout("tmo", 1'b0);
    run_timeout("tmo_ack", 1'b1);

    // Reset in the second BUSY cycle of a halfword load.
    alu_op(4'd0, 5'd2, 32'h0000_1111);
    @(negedge clk);
    mem_op = 4'd2; mem_addr = 32'h0000_0102; reg_waddr = 5'd9; reg_we = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rmid_req", {31'd0, dbus_req}, 32'd0);
    check("rmid_stall", {31'd0, stall}, 32'd0);
    check("rmid_wb_data", wb_wdata, 32'd0);
    check("rmid_addr", dbus_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_nop();
    run_access("post_rst", 4'd4, 32'h0000_0101, 32'd0, 32'h80AA_BBCC, 5'd10, 0,
               32'h0000_0100, 4'b1111, 32'd0, 1'b1, 32'h0000_00BB);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
